// File: rtl/wresp_pkg.sv
// Shared definitions for the write-response ID tracker.
// Holds the FSM state encoding and the default parameter values used by
// wresp_id_tracker and its table sub-module.
package wresp_pkg;

  // FSM state codes
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FULL = 2'b10,
    ERR  = 2'b11
  } wresp_state_t;

  localparam int DEFAULT_IDW   = 4;
  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/wresp_id_table.sv
// Outstanding-write table: DEPTH entries of {valid, id}.
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   alloc_en, alloc_id     write alloc_id into the slot reported on alloc_idx
//   free_en, free_idx      invalidate slot free_idx
//   lookup_id              ID searched for among the valid entries
//   free_found, alloc_idx  lowest free slot (combinational)
//   match_found, match_idx lowest valid slot whose id equals lookup_id (combinational)
// Both encoders look only at the registered contents, so a slot freed in a cycle
// is not offered for allocation until the next one, and a same-cycle allocation
// is never seen by the lookup.
module wresp_id_table
  import wresp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDW   = DEFAULT_IDW,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alloc_en,
  input  logic [IDW-1:0] alloc_id,
  input  logic           free_en,
  input  logic [IW-1:0]  free_idx,
  input  logic [IDW-1:0] lookup_id,
  output logic           free_found,
  output logic [IW-1:0]  alloc_idx,
  output logic           match_found,
  output logic [IW-1:0]  match_idx
);

  logic [DEPTH-1:0] valid_q;
  logic [IDW-1:0]   id_q [DEPTH];

  // Priority encoders; scanning from the top down leaves the lowest hit last.
  always_comb begin
    free_found  = 1'b0;
    alloc_idx   = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        alloc_idx  = IW'(i);
      end
      if (valid_q[i] && (id_q[i] == lookup_id)) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
    end
  end

  // Allocation and free always target different slots (free vs. valid), so
  // both may happen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      if (free_en) begin
        valid_q[free_idx] <= 1'b0;
      end
      if (alloc_en) begin
        valid_q[alloc_idx] <= 1'b1;
        id_q[alloc_idx]    <= alloc_id;
      end
    end
  end

endmodule

// File: rtl/wresp_id_tracker.sv
// Tracks outstanding AXI writes between the write-data manager and the B channel.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   finish_wd, finish_id      log a completed write-data burst
//   issue_ready               a finish_wd would be accepted this cycle
//   bvalid, bready, bid,bcomp B channel (this block owns bready)
//   finish_wresp, _id         registered pulse for a matched response
//   wresp_err                 registered pulse: error response, unknown bid, or overflow
//   err_sticky, err_clr       latched error and its clear
//   outstanding               number of valid table entries
module wresp_id_tracker
  import wresp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDW   = DEFAULT_IDW,
  localparam int IW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           finish_wd,
  input  logic [IDW-1:0] finish_id,
  output logic           issue_ready,
  input  logic           bvalid,
  output logic           bready,
  input  logic [IDW-1:0] bid,
  input  logic           bcomp,
  output logic           finish_wresp,
  output logic [IDW-1:0] finish_wresp_id,
  output logic           wresp_err,
  output logic           err_sticky,
  input  logic           err_clr,
  output logic [CW-1:0]  outstanding
);

  wresp_state_t   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           live_q;
  logic           resp_q, resp_err_q;
  logic [IDW-1:0] resp_id_q;

  logic           free_found, match_found;
  logic [IW-1:0]  alloc_idx, match_idx;
  logic           accept, drop, hs, hit, miss, new_err;

  // live_q keeps issue_ready low while reset is asserted and goes high on the
  // first edge after release, so issue_ready comes only from registers.
  assign issue_ready = live_q && ((state_q == IDLE) || (state_q == BUSY));
  assign bready      = (state_q != IDLE);

  assign accept  = finish_wd && issue_ready && free_found;
  assign drop    = finish_wd && !accept;
  assign hs      = bvalid && bready;
  assign hit     = hs && match_found;
  assign miss    = hs && !match_found;
  assign new_err = drop || miss;

  wresp_id_table #(
    .DEPTH(DEPTH),
    .IDW  (IDW)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (accept),
    .alloc_id   (finish_id),
    .free_en    (hit),
    .free_idx   (match_idx),
    .lookup_id  (bid),
    .free_found (free_found),
    .alloc_idx  (alloc_idx),
    .match_found(match_found),
    .match_idx  (match_idx)
  );

  // Counter and sticky-error next values; a new error beats err_clr.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !hit) begin
      cnt_d = cnt_q + CW'(1);
    end else if (hit && !accept) begin
      cnt_d = cnt_q - CW'(1);
    end
    err_d = err_q;
    if (new_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Next state: outside ERR, and when leaving it, the state follows the
  // next occupancy value.
  always_comb begin
    state_d = state_q;
    if (new_err) begin
      state_d = ERR;
    end else if ((state_q != ERR) || err_clr) begin
      if (cnt_d == '0) begin
        state_d = IDLE;
      end else if (cnt_d == CW'(DEPTH)) begin
        state_d = FULL;
      end else begin
        state_d = BUSY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      live_q     <= 1'b0;
      resp_q     <= 1'b0;
      resp_id_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      live_q     <= 1'b1;
      resp_q     <= hit;
      resp_id_q  <= hit ? bid : '0;
      resp_err_q <= new_err || (hit && !bcomp);
    end
  end

  assign finish_wresp    = resp_q;
  assign finish_wresp_id = resp_id_q;
  assign wresp_err       = resp_err_q;
  assign err_sticky      = err_q;
  assign outstanding     = cnt_q;

endmodule

// File: tb/tb_wresp_id_tracker.sv
// Self-checking bench for wresp_id_tracker (DEPTH=4, IDW=4).
// A behavioural model tracks outstanding IDs and the sticky error; the response
// events it predicts are queued when stimulus is driven and popped when the
// registered outputs appear.
module tb_wresp_id_tracker;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           finish_wd;
  logic [IDW-1:0] finish_id;
  logic           issue_ready;
  logic           bvalid;
  logic           bready;
  logic [IDW-1:0] bid;
  logic           bcomp;
  logic           finish_wresp;
  logic [IDW-1:0] finish_wresp_id;
  logic           wresp_err;
  logic           err_sticky;
  logic           err_clr;
  logic [CW-1:0]  outstanding;

  typedef struct {
    bit             resp;
    logic [IDW-1:0] id;
    bit             err;
  } exp_t;

  exp_t sb[$];
  int   mdl_ids[$];
  bit   mdl_err;
  int   tests_run = 0;
  int   tests_failed = 0;

  wresp_id_tracker #(.DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk            (clk),
    .rst            (rst),
    .finish_wd      (finish_wd),
    .finish_id      (finish_id),
    .issue_ready    (issue_ready),
    .bvalid         (bvalid),
    .bready         (bready),
    .bid            (bid),
    .bcomp          (bcomp),
    .finish_wresp   (finish_wresp),
    .finish_wresp_id(finish_wresp_id),
    .wresp_err      (wresp_err),
    .err_sticky     (err_sticky),
    .err_clr        (err_clr),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    finish_wd = 1'b0;
    finish_id = '0;
    bvalid    = 1'b0;
    bid       = '0;
    bcomp     = 1'b0;
    err_clr   = 1'b0;
  endtask

  // Drive one cycle, step the model with the pre-edge state, then compare.
  task automatic applyStimulus(input bit fwd, input int fid, input bit bv, input int b,
                               input bit bc, input bit clr);
    bit   m_bready, m_ready, acc, drp, hsk, hit;
    int   pos;
    exp_t e;
    exp_t got;
    @(negedge clk);
    finish_wd = fwd;
    finish_id = IDW'(fid);
    bvalid    = bv;
    bid       = IDW'(b);
    bcomp     = bc;
    err_clr   = clr;
    m_bready = mdl_err || (mdl_ids.size() > 0);
    m_ready  = !mdl_err && (mdl_ids.size() < DEPTH);
    acc = fwd && m_ready;
    drp = fwd && !m_ready;
    hsk = bv && m_bready;
    hit = 1'b0;
    pos = -1;
    if (hsk) begin
      foreach (mdl_ids[i]) begin
        if (pos < 0 && mdl_ids[i] == b) pos = i;
      end
      hit = (pos >= 0);
      if (hit) mdl_ids.delete(pos);
    end
    if (acc) mdl_ids.push_back(fid);
    if (drp || (hsk && !hit)) mdl_err = 1'b1;
    else if (clr) mdl_err = 1'b0;
    e.resp = hit;
    e.id   = hit ? IDW'(b) : '0;
    e.err  = drp || (hsk && !hit) || (hit && !bc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput("finish_wresp", 32'(finish_wresp), 32'(got.resp));
    if (got.resp) checkOutput("finish_wresp_id", 32'(finish_wresp_id), 32'(got.id));
    checkOutput("wresp_err", 32'(wresp_err), 32'(got.err));
    checkOutput("outstanding", 32'(outstanding), 32'(mdl_ids.size()));
    checkOutput("err_sticky", 32'(err_sticky), 32'(mdl_err));
    checkOutput("bready", 32'(bready), 32'(mdl_err || (mdl_ids.size() > 0)));
    checkOutput("issue_ready", 32'(issue_ready), 32'(!mdl_err && (mdl_ids.size() < DEPTH)));
    clearInputs();
  endtask

  task automatic issueId(input int id);
    applyStimulus(1'b1, id, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic respond(input int id, input bit ok);
    applyStimulus(1'b0, 0, 1'b1, id, ok, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_outstanding"}, 32'(outstanding), 0);
    checkOutput({tag, "_bready"}, 32'(bready), 0);
    checkOutput({tag, "_issue_ready"}, 32'(issue_ready), 0);
    checkOutput({tag, "_finish_wresp"}, 32'(finish_wresp), 0);
    checkOutput({tag, "_wresp_err"}, 32'(wresp_err), 0);
    checkOutput({tag, "_err_sticky"}, 32'(err_sticky), 0);
  endtask

  initial begin
    clearInputs();
    mdl_err = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_issue_ready", 32'(issue_ready), 1);
    checkOutput("post_reset_bready", 32'(bready), 0);

    // T1 single write
    issueId(3);
    respond(3, 1'b1);

    // T2 fill and out-of-order completion
    issueId(1); issueId(2); issueId(5); issueId(7);
    respond(5, 1'b1); respond(1, 1'b1); respond(7, 1'b1); respond(2, 1'b1);

    // T3 overflow in FULL, then clear back to FULL and drain
    issueId(1); issueId(2); issueId(5); issueId(7);
    issueId(9);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    respond(7, 1'b1); respond(5, 1'b1); respond(2, 1'b1); respond(1, 1'b1);

    // T4 unknown bid; clear coinciding with a new error loses
    issueId(2);
    respond(6, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 6, 1'b1, 1'b1);
    respond(2, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

    // Error response on a known ID: completes, pulses error, no sticky
    issueId(8);
    respond(8, 1'b0);

    // T5 same-cycle issue and response on a duplicated ID
    issueId(4); issueId(4);
    applyStimulus(1'b1, 4, 1'b1, 4, 1'b1, 1'b0);
    respond(4, 1'b1); respond(4, 1'b1);

    // T6 reset mid-operation with a completion pulse showing and bvalid high
    issueId(1); issueId(2); issueId(3); issueId(6);
    respond(6, 1'b1);
    bvalid = 1'b1;
    bid    = IDW'(1);
    bcomp  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("midop_reset");
    mdl_ids.delete();
    mdl_err = 1'b0;
    sb.delete();
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rerelease_outstanding", 32'(outstanding), 0);
    checkOutput("rerelease_issue_ready", 32'(issue_ready), 1);
    checkOutput("rerelease_bready", 32'(bready), 0);
    issueId(11);
    respond(11, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
